hazard_stall_controller: RTL

//  Sequences the IF/ID and ID/EX pipeline registers and the PC of the RV32IM core.

---
 rtl/hazard_stall_controller_pkg.sv | 17 +
 rtl/hazard_stall_controller_muldiv_stall_counter.sv | 28 ++
 rtl/hazard_stall_controller.sv | 131 +++++++++++++
 3 files changed

// File: rtl/hazard_stall_controller_pkg.sv
// Shared types and constants for the hazard/stall controller.
// Pulled in by the top and its M-unit hold counter.
package hazard_stall_controller_pkg;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_MULDIV = 1'b1
    } state_t;

    localparam logic [4:0]  REG_X0 = 5'd0;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    function automatic int max_lat(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_stall_controller_muldiv_stall_counter.sv
// Remaining-hold counter for a multi-cycle MUL/DIV in EX.
// Loaded on issue, decremented per hold cycle, flags the last one.
module muldiv_stall_counter #(
    parameter int MC_W = 5
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            load,
    input  logic [MC_W-1:0] load_val,
    input  logic            dec,
    output logic            last
);

    logic [MC_W-1:0] mcnt;

    // Load on issue, count down while holding, clear on reset
    always_ff @(posedge CLK) begin
        if (RESET)
            mcnt <= '0;
        else if (load)
            mcnt <= load_val;
        else if (dec && mcnt != '0)
            mcnt <= mcnt - MC_W'(1);
    end

    assign last = (mcnt == MC_W'(1));

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing: load-use stall, branch flush, M-unit freeze.
// Also keeps stall and flush performance counters.
module hazard_stall_controller
    import hazard_stall_controller_pkg::*;
#(
    parameter int MUL_LATENCY = 2,
    parameter int DIV_LATENCY = 32,
    parameter int CNT_W       = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [4:0]       ID_RS1,
    input  logic [4:0]       ID_RS2,
    input  logic             ID_USES_RS1,
    input  logic             ID_USES_RS2,
    input  logic             ID_IS_MUL,
    input  logic             ID_IS_DIV,
    input  logic             EX_MEM_READ,
    input  logic [4:0]       EX_RD,
    input  logic             EX_BRANCH_TAKEN,
    input  logic             MULDIV_DONE,
    output logic             PC_WRITE,
    output logic             IF_ID_BUBBLE,
    output logic             IF_ID_FLUSH,
    output logic             ID_EX_BUBBLE,
    output logic             ID_EX_HOLD,
    output logic             EX_MEM_BUBBLE,
    output logic             MULDIV_BUSY,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] FLUSH_CNT
);

    localparam int MAX_LAT = max_lat(MUL_LATENCY, DIV_LATENCY);
    localparam int MC_W    = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

    state_t          state_q;
    state_t          state_d;
    logic            load_use;
    logic            m_load;
    logic            m_dec;
    logic            m_last;
    logic [MC_W-1:0] m_val;

    assign load_use = EX_MEM_READ && (EX_RD != REG_X0) &&
                      ((ID_USES_RS1 && ID_RS1 == EX_RD) ||
                       (ID_USES_RS2 && ID_RS2 == EX_RD));

    muldiv_stall_counter #(.MC_W(MC_W)) u_mcnt (
        .CLK      (CLK),
        .RESET    (RESET),
        .load     (m_load),
        .load_val (m_val),
        .dec      (m_dec),
        .last     (m_last)
    );

    // State register
    always_ff @(posedge CLK) begin
        if (RESET)
            state_q <= ST_RUN;
        else
            state_q <= state_d;
    end

    // Next state and pipeline controls for the current cycle
    always_comb begin
        state_d       = state_q;
        PC_WRITE      = 1'b1;
        IF_ID_BUBBLE  = 1'b0;
        IF_ID_FLUSH   = 1'b0;
        ID_EX_BUBBLE  = 1'b0;
        ID_EX_HOLD    = 1'b0;
        EX_MEM_BUBBLE = 1'b0;
        MULDIV_BUSY   = 1'b0;
        m_load        = 1'b0;
        m_dec         = 1'b0;
        m_val         = '0;
        if (RESET) begin
            state_d      = ST_RUN;
            PC_WRITE     = 1'b0;
            IF_ID_FLUSH  = 1'b1;
            ID_EX_BUBBLE = 1'b1;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (EX_BRANCH_TAKEN) begin
                        IF_ID_FLUSH  = 1'b1;
                        ID_EX_BUBBLE = 1'b1;
                    end else if (load_use) begin
                        PC_WRITE     = 1'b0;
                        IF_ID_BUBBLE = 1'b1;
                        ID_EX_BUBBLE = 1'b1;
                    end else if (ID_IS_DIV && DIV_LATENCY > 1) begin
                        state_d = ST_MULDIV;
                        m_load  = 1'b1;
                        m_val   = MC_W'(DIV_LATENCY - 1);
                    end else if (ID_IS_MUL && MUL_LATENCY > 1) begin
                        state_d = ST_MULDIV;
                        m_load  = 1'b1;
                        m_val   = MC_W'(MUL_LATENCY - 1);
                    end
                end
                ST_MULDIV: begin
                    PC_WRITE      = 1'b0;
                    IF_ID_BUBBLE  = 1'b1;
                    ID_EX_HOLD    = 1'b1;
                    EX_MEM_BUBBLE = 1'b1;
                    MULDIV_BUSY   = 1'b1;
                    m_dec         = 1'b1;
                    if (m_last || MULDIV_DONE)
                        state_d = ST_RUN;
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // Stall and flush performance counters, wrapping
    always_ff @(posedge CLK) begin
        if (RESET) begin
            STALL_CNT <= '0;
            FLUSH_CNT <= '0;
        end else begin
            if (!PC_WRITE)
                STALL_CNT <= STALL_CNT + CNT_W'(1);
            if (IF_ID_FLUSH)
                FLUSH_CNT <= FLUSH_CNT + CNT_W'(1);
        end
    end

endmodule
